dmem_arbiter: RTL



---
 rtl/dmem_arbiter_pkg.sv | 27 ++
 rtl/dmem_arbiter_arb_pick.sv | 30 +++
 rtl/dmem_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings, widths and request payload for the data-memory arbiter.
package dmem_arbiter_pkg;

   localparam int unsigned ADDR_W = 15;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned LAT_W  = 3;
   localparam int unsigned WAIT_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_e;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_arb_pick.sv
// Combinational winner selection between CPU and DMA requesters.
module arb_pick
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned PRIO_MODE = 0
) (
   input  logic cpu_req_i,
   input  logic dma_req_i,
   input  logic last_owner_i,
   input  logic starve_i,
   output logic winner_c_o,
   output logic valid_c_o
);

   // Ties go to the non-last owner (round-robin) or to the CPU unless DMA is starving.
   always_comb begin
      winner_c_o = OWN_CPU;
      valid_c_o  = cpu_req_i | dma_req_i;
      if (cpu_req_i && dma_req_i) begin
         if (PRIO_MODE == 0) begin
            winner_c_o = (last_owner_i == OWN_CPU) ? OWN_DMA : OWN_CPU;
         end else begin
            winner_c_o = starve_i ? OWN_DMA : OWN_CPU;
         end
      end else if (dma_req_i) begin
         winner_c_o = OWN_DMA;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester sequencer for the single-port data memory: arbitrates, strobes
// the memory for MEM_LAT cycles, captures read data and pulses done.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned MEM_LAT      = 1,
   parameter int unsigned PRIO_MODE    = 0,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_done,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_owner_q, last_owner_d;
   logic                we_q, we_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic                cpu_gnt_q, cpu_gnt_d;
   logic                dma_gnt_q, dma_gnt_d;
   logic                cpu_done_q, cpu_done_d;
   logic                dma_done_q, dma_done_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
   logic                busy_q, busy_d;

   logic                pick_winner_c;
   logic                pick_valid_c;
   logic                starve_c;
   mem_req_t            cpu_req_s, dma_req_s, sel_req_s;

   assign starve_c  = (wait_q >= WAIT_W'(STARVE_LIMIT));
   assign cpu_req_s = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
   assign dma_req_s = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
   assign sel_req_s = (pick_winner_c == OWN_DMA) ? dma_req_s : cpu_req_s;

   arb_pick #(
      .PRIO_MODE (PRIO_MODE)
   ) u_arb_pick (
      .cpu_req_i    (cpu_req),
      .dma_req_i    (dma_req),
      .last_owner_i (last_owner_q),
      .starve_i     (starve_c),
      .winner_c_o   (pick_winner_c),
      .valid_c_o    (pick_valid_c)
   );

   // Outputs are registered, so every *_d below is the value for the next cycle.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      we_d         = we_q;
      lat_d        = lat_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      cpu_gnt_d    = 1'b0;
      dma_gnt_d    = 1'b0;
      cpu_done_d   = 1'b0;
      dma_done_d   = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dma_rdata_d  = dma_rdata_q;

      case (state_q)
         IDLE: begin
            if (pick_valid_c) begin
               state_d     = ACCESS;
               owner_d     = pick_winner_c;
               we_d        = sel_req_s.we;
               mem_addr_d  = sel_req_s.addr;
               mem_wdata_d = sel_req_s.wdata;
               lat_d       = LAT_W'(MEM_LAT - 1);
               mem_read_d  = ~sel_req_s.we;
               mem_write_d = sel_req_s.we;
               cpu_gnt_d   = (pick_winner_c == OWN_CPU);
               dma_gnt_d   = (pick_winner_c == OWN_DMA);
            end
         end
         ACCESS: begin
            cpu_gnt_d = (owner_q == OWN_CPU);
            dma_gnt_d = (owner_q == OWN_DMA);
            if (lat_q == '0) begin
               state_d = CAPTURE;
            end else begin
               lat_d       = lat_q - LAT_W'(1);
               mem_read_d  = ~we_q;
               mem_write_d = we_q;
            end
         end
         CAPTURE: begin
            state_d    = DONE;
            cpu_done_d = (owner_q == OWN_CPU);
            dma_done_d = (owner_q == OWN_DMA);
            if (!we_q) begin
               if (owner_q == OWN_CPU) begin
                  cpu_rdata_d = mem_rdata;
               end else begin
                  dma_rdata_d = mem_rdata;
               end
            end
         end
         DONE: begin
            state_d      = IDLE;
            last_owner_d = owner_q;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // DMA starvation counter: counts cycles DMA waits without owning the memory.
   always_comb begin
      wait_d = wait_q;
      if (!dma_req) begin
         wait_d = '0;
      end else if (state_q == IDLE && pick_valid_c && pick_winner_c == OWN_DMA) begin
         wait_d = '0;
      end else if (!(state_q != IDLE && owner_q == OWN_DMA) && wait_q != '1) begin
         wait_d = wait_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= OWN_CPU;
         last_owner_q <= OWN_DMA;
         we_q         <= 1'b0;
         lat_q        <= '0;
         wait_q       <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         cpu_gnt_q    <= 1'b0;
         dma_gnt_q    <= 1'b0;
         cpu_done_q   <= 1'b0;
         dma_done_q   <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         we_q         <= we_d;
         lat_q        <= lat_d;
         wait_q       <= wait_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         cpu_gnt_q    <= cpu_gnt_d;
         dma_gnt_q    <= dma_gnt_d;
         cpu_done_q   <= cpu_done_d;
         dma_done_q   <= dma_done_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
         busy_q       <= busy_d;
      end
   end

   assign cpu_gnt   = cpu_gnt_q;
   assign cpu_done  = cpu_done_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dma_gnt   = dma_gnt_q;
   assign dma_done  = dma_done_q;
   assign dma_rdata = dma_rdata_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule
